// File: rtl/conv_stream_kxk.sv
// conv_stream_kxk
// Streaming KxK 2-D convolution. Each accepted beat is one image column of K
// pixels; the block keeps a K-column sliding window and multiplies it by a
// runtime-loadable KxK kernel (reset kernel = all ones, i.e. a box sum).
// The first K-1 columns of every row are warm-up and produce no output.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   flush           synchronous clear of window counter and pipeline valids
//   w_we/w_addr/w_data  kernel write, index r*K+c (c=0 oldest column)
//   in_valid/in_ready/in_col   column input; lane r = in_col[(K-r)*DW-1 -: DW]
//   out_valid/out_ready/out_data/out_last  result output, last = end of row
module conv_stream_kxk #(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 3,
  parameter int IMG_WIDTH  = 224,
  parameter int ACC_WIDTH  = 20,
  parameter int SIGNED     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         w_we,
  input  logic [$clog2(K*K)-1:0]       w_addr,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [K*DATA_WIDTH-1:0]      in_col,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_data,
  output logic                         out_last
);

  localparam int KK = K * K;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);

  logic [DATA_WIDTH-1:0]  w_q [KK];
  logic [DATA_WIDTH-1:0]  w_d [KK];
  logic [CW-1:0]          col_cnt_q, col_cnt_d;
  logic [DATA_WIDTH-1:0]  win_p0_q [K][K];
  logic [DATA_WIDTH-1:0]  win_p0_d [K][K];
  logic                   vld_p0_q, vld_p0_d, last_p0_q, last_p0_d;
  logic signed [PW-1:0]   prod_p1_q [KK];
  logic signed [PW-1:0]   prod_p1_d [KK];
  logic                   vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  logic                   en, acc_col;
  logic signed [ACC_WIDTH-1:0] sum;

  function automatic logic signed [PW-1:0] mult(input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    logic signed [PW-1:0] ps;
    logic [PW-1:0]        pu;
    if (SIGNED != 0) begin
      ps = PW'($signed(a)) * PW'($signed(b));
      return ps;
    end else begin
      pu = PW'(a) * PW'(b);
      return signed'(pu);
    end
  endfunction

  // Products are extended by their own signedness; a narrow ACC_WIDTH keeps LSBs.
  function automatic logic signed [ACC_WIDTH-1:0] ext_prod(input logic signed [PW-1:0] p);
    if (SIGNED != 0) return ACC_WIDTH'(p);
    else             return signed'(ACC_WIDTH'($unsigned(p)));
  endfunction

  // Single advance enable: the whole pipeline freezes while the output is stalled.
  assign en       = !vld_p2_q || out_ready;
  assign in_ready = en;
  assign acc_col  = in_valid && en && !flush;

  always_comb begin
    w_d        = w_q;
    col_cnt_d  = col_cnt_q;
    win_p0_d   = win_p0_q;
    vld_p0_d   = vld_p0_q;
    last_p0_d  = last_p0_q;
    prod_p1_d  = prod_p1_q;
    vld_p1_d   = vld_p1_q;
    last_p1_d  = last_p1_q;
    out_data_d = out_data_q;
    vld_p2_d   = vld_p2_q;
    last_p2_d  = last_p2_q;
    sum        = '0;

    // Kernel writes are independent of flush and of pipeline stalls.
    if (w_we && (int'(w_addr) < KK)) w_d[w_addr] = w_data;

    for (int i = 0; i < KK; i++) sum = sum + ext_prod(prod_p1_q[i]);

    if (flush) begin
      col_cnt_d = '0;
      vld_p0_d  = 1'b0;
      vld_p1_d  = 1'b0;
      vld_p2_d  = 1'b0;
      last_p0_d = 1'b0;
      last_p1_d = 1'b0;
      last_p2_d = 1'b0;
    end else if (en) begin
      // stage 0: window shift and eligibility
      vld_p0_d  = 1'b0;
      last_p0_d = 1'b0;
      if (acc_col) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) win_p0_d[r][c] = win_p0_q[r][c+1];
          win_p0_d[r][K-1] = in_col[(K-r)*DATA_WIDTH-1 -: DATA_WIDTH];
        end
        vld_p0_d  = (col_cnt_q >= CW'(K - 1));
        last_p0_d = (col_cnt_q == CW'(IMG_WIDTH - 1));
        col_cnt_d = last_p0_d ? '0 : col_cnt_q + CW'(1);
      end
      // stage 1: products, weights sampled at this edge
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          prod_p1_d[r*K+c] = mult(win_p0_q[r][c], w_q[r*K+c]);
      vld_p1_d  = vld_p0_q;
      last_p1_d = last_p0_q;
      // stage 2: adder tree into the output register
      out_data_d = sum;
      vld_p2_d   = vld_p1_q;
      last_p2_d  = last_p1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KK; i++) w_q[i] <= DATA_WIDTH'(1);
      col_cnt_q  <= '0;
      vld_p0_q   <= 1'b0;
      last_p0_q  <= 1'b0;
      vld_p1_q   <= 1'b0;
      last_p1_q  <= 1'b0;
      out_data_q <= '0;
      vld_p2_q   <= 1'b0;
      last_p2_q  <= 1'b0;
    end else begin
      w_q        <= w_d;
      col_cnt_q  <= col_cnt_d;
      vld_p0_q   <= vld_p0_d;
      last_p0_q  <= last_p0_d;
      vld_p1_q   <= vld_p1_d;
      last_p1_q  <= last_p1_d;
      out_data_q <= out_data_d;
      vld_p2_q   <= vld_p2_d;
      last_p2_q  <= last_p2_d;
    end
  end

  // Window and product registers carry no reset; their valids gate them.
  always_ff @(posedge clk) begin
    win_p0_q  <= win_p0_d;
    prod_p1_q <= prod_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_last  = last_p2_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_stream_kxk.sv
module tb_conv_stream_kxk;

  logic        clk = 1'b0;
  logic        rst, flush, w_we, in_valid, out_ready;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;
  logic [23:0] in_col;
  logic        rdy_u, vld_u, last_u, rdy_s, vld_s, last_s;
  logic [19:0] data_u, data_s;

  always #5 clk = ~clk;

  // Unsigned instance, short rows.
  conv_stream_kxk #(.DATA_WIDTH(8), .K(3), .IMG_WIDTH(5), .ACC_WIDTH(20), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .flush(flush), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(rdy_u), .in_col(in_col),
    .out_valid(vld_u), .out_ready(out_ready), .out_data(data_u), .out_last(last_u));

  // Signed instance, 8-column rows.
  conv_stream_kxk #(.DATA_WIDTH(8), .K(3), .IMG_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(rdy_s), .in_col(in_col),
    .out_valid(vld_s), .out_ready(out_ready), .out_data(data_s), .out_last(last_s));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state; sel_s picks which instance is under test.
  bit          sel_s = 1'b0;
  int          img_w = 5;
  logic [7:0]  wm [9];
  logic [7:0]  mw [3][3];
  int          mcnt;
  logic [20:0] exp_q[$];
  logic [20:0] got_q[$];
  bit          rnd_en = 1'b0;
  bit          stall_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [20:0] prev_out;

  function automatic int sx(input logic [7:0] v);
    if (sel_s) return int'($signed(v));
    else       return int'(v);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 9; i++) wm[i] = 8'd1;
    mcnt = 0;
    exp_q.delete();
    got_q.delete();
  endfunction

  function automatic void model_push(input logic [23:0] col);
    int          s;
    logic [31:0] sv;
    for (int r = 0; r < 3; r++) begin
      mw[r][0] = mw[r][1];
      mw[r][1] = mw[r][2];
      mw[r][2] = col[(3-r)*8-1 -: 8];
    end
    if (mcnt >= 2) begin
      s = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) s += sx(mw[r][c]) * sx(wm[r*3+c]);
      sv = s;
      exp_q.push_back({(mcnt == img_w - 1), sv[19:0]});
    end
    mcnt = (mcnt == img_w - 1) ? 0 : mcnt + 1;
  endfunction

  always @(negedge clk) begin
    if (!sel_s && vld_u && out_ready) got_q.push_back({last_u, data_u});
    if (sel_s && vld_s && out_ready) got_q.push_back({last_s, data_s});
    if (stall_en) begin
      if (prev_stall) check("stall_hold", {11'd0, vld_s, last_s, data_s}, {11'd0, 1'b1, prev_out});
      prev_stall <= vld_s && !out_ready;
      prev_out   <= {last_s, data_s};
    end else begin
      prev_stall <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push(input logic [23:0] col);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_col   = col;
    while (!(sel_s ? rdy_s : rdy_u) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("push_timeout", n, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_push(col);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    w_we   = 1'b1;
    w_addr = 4'(a);
    w_data = d;
    @(posedge clk);
    #1 w_we = 1'b0;
    wm[a] = d;
  endtask

  task automatic set_all(input logic [7:0] d);
    for (int i = 0; i < 9; i++) wr(i, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; w_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic drain(input string tag, output int lasts);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_cnt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < got_q.size()) ? {11'd0, got_q[i]} : 32'hxxxxxxxx, {11'd0, exp_q[i]});
    lasts = 0;
    foreach (got_q[i]) if (got_q[i][20]) lasts++;
  endtask

  int lasts;

  initial begin
    rst = 1'b1; flush = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; in_col = '0; out_ready = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_valid", vld_u, 0);
    check("rst_last", last_u, 0);
    check("rst_data", data_u, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_u", rdy_u, 1);
    check("rst_ready_s", rdy_s, 1);

    // Box sum with reset kernel, plus 3-edge latency from the 3rd column.
    repeat (3) push(24'h010101);
    @(negedge clk); check("lat_t0", vld_u, 0);
    @(negedge clk); check("lat_t1", vld_u, 0);
    @(negedge clk); check("lat_t2", vld_u, 1);
    check("lat_data", data_u, 9);
    repeat (2) push(24'h010101);
    drain("box", lasts);
    check("box_lasts", lasts, 1);
    check("box_v0", got_q[0], {1'b0, 20'd9});
    check("box_v2", got_q[2], {1'b1, 20'd9});

    // Centre-only kernel: middle lane of middle column (n+1 for column n) times 2.
    do_reset();
    set_all(8'd0);
    wr(4, 8'd2);
    for (int n = 0; n < 5; n++) push({8'(n), 8'(n + 1), 8'(n + 2)});
    drain("centre", lasts);
    check("centre0", got_q[0][19:0], 4);
    check("centre1", got_q[1][19:0], 6);
    check("centre2", got_q[2][19:0], 8);

    // Unsigned extreme: 9 * 255 * 255.
    do_reset();
    set_all(8'd255);
    repeat (5) push(24'hFFFFFF);
    drain("umax", lasts);
    for (int i = 0; i < 3; i++) check("umax_val", got_q[i][19:0], 20'd585225);

    // Signed extreme: 9 * -128 * 127 = -146304.
    sel_s = 1'b1; img_w = 8;
    do_reset();
    set_all(8'd127);
    repeat (8) push(24'h808080);
    drain("smin", lasts);
    for (int i = 0; i < 6; i++) check("smin_val", got_q[i][19:0], 20'hDC480);
    check("smin_lasts", lasts, 1);

    // Random data and kernel over 3 rows with random backpressure.
    do_reset();
    for (int i = 0; i < 9; i++) wr(i, 8'($urandom_range(0, 255)));
    stall_en = 1'b1;
    rnd_en   = 1'b1;
    for (int i = 0; i < 24; i++) push(24'($urandom));
    @(posedge clk);
    rnd_en = 1'b0;
    #2 out_ready = 1'b1;
    drain("rand", lasts);
    stall_en = 1'b0;
    check("rand_lasts", lasts, 3);

    // Flush after 2 columns; the flushed column is discarded, the write lands.
    sel_s = 1'b0; img_w = 5;
    do_reset();
    repeat (2) push(24'h010101);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_col = 24'h050505;
    w_we = 1'b1; w_addr = 4'd4; w_data = 8'd3;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0; w_we = 1'b0;
    wm[4] = 8'd3;
    mcnt = 0;
    repeat (4) @(negedge clk);
    check("flush_quiet", vld_u, 0);
    repeat (5) push(24'h010101);
    drain("flush", lasts);
    for (int i = 0; i < 3; i++) check("flush_val", got_q[i][19:0], 11);
    check("flush_lasts", lasts, 1);

    // Reset mid-stream with a custom kernel and a stalled output.
    do_reset();
    set_all(8'd2);
    out_ready = 1'b0;
    repeat (3) push(24'h010101);
    repeat (4) @(negedge clk);
    check("pre_rst_valid", vld_u, 1);
    check("pre_rst_data", data_u, 18);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", vld_u, 0);
    check("mid_rst_data", data_u, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    out_ready = 1'b1;
    repeat (5) push(24'h010203);
    drain("post_rst", lasts);
    for (int i = 0; i < 3; i++) check("post_rst_val", got_q[i][19:0], 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
